// File: rtl/clkg_seq.sv
// Clock-configuration sequencer on the JTAG clock. It orders gate, mux, divider and oscillator changes for the clock generator so they are glitch-safe.
// Optional feature: define CLKG_SEQ_FASTPATH_EN to skip the full sequence when only the branch enables change.
module clkg_seq #(
  parameter int GATE_WAIT  = 4,
  parameter int OSC_SETTLE = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       i_osc_en,
  input  logic [2:0] i_div,
  input  logic       i_smp_en,
  input  logic       i_ncm_en,
  input  logic       i_msk_en,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_drop,
  output logic       o_osc_en,
  output logic       o_clk_en,
  output logic [2:0] o_clk_div,
  output logic       o_div_rst_n,
  output logic       o_smp_en,
  output logic       o_ncm_en,
  output logic       o_msk_en
);

  localparam int MAXW = (GATE_WAIT > OSC_SETTLE) ? GATE_WAIT : OSC_SETTLE;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] GW_LOAD = CW'(GATE_WAIT - 1);
  localparam logic [CW-1:0] OS_LOAD = CW'(OSC_SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE, GATE_OFF, CLK_OFF, APPLY, SETTLE, CLK_ON, GATE_ON
  } state_t;

  state_t        r_state, w_nextState;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_shOsc, w_shOsc;
  logic [2:0]    r_shDiv, w_shDiv;
  logic          r_shSmp, w_shSmp, r_shNcm, w_shNcm, r_shMsk, w_shMsk;
  logic          r_oscChg, w_oscChg;
  logic          r_busy, w_busy, r_done, w_done, r_drop, w_drop;
  logic          r_oscEn, w_oscEn, r_clkEn, w_clkEn, r_divRstN, w_divRstN;
  logic [2:0]    r_clkDiv, w_clkDiv;
  logic          r_smpEn, w_smpEn, r_ncmEn, w_ncmEn, r_mskEn, w_mskEn;
  logic          w_cntZero, w_fast;

  assign w_cntZero = (r_cnt == '0);

`ifdef CLKG_SEQ_FASTPATH_EN
  assign w_fast = (i_osc_en == r_oscEn) && (i_div == r_clkDiv) && r_divRstN;
`else
  assign w_fast = 1'b0;
`endif

  // Each transition writes the registered outputs of the state being entered.
  always_comb begin
    w_nextState = r_state;
    w_cnt       = r_cnt;
    w_shOsc     = r_shOsc;
    w_shDiv     = r_shDiv;
    w_shSmp     = r_shSmp;
    w_shNcm     = r_shNcm;
    w_shMsk     = r_shMsk;
    w_oscChg    = r_oscChg;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_drop      = r_drop | (i_req && (r_state != IDLE));
    w_oscEn     = r_oscEn;
    w_clkEn     = r_clkEn;
    w_clkDiv    = r_clkDiv;
    w_divRstN   = r_divRstN;
    w_smpEn     = r_smpEn;
    w_ncmEn     = r_ncmEn;
    w_mskEn     = r_mskEn;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_shOsc = i_osc_en;
          w_shDiv = i_div;
          w_shSmp = i_smp_en;
          w_shNcm = i_ncm_en;
          w_shMsk = i_msk_en;
          w_drop  = 1'b0;
          w_busy  = 1'b1;
          if (w_fast) begin
            w_nextState = GATE_ON;
            w_smpEn     = i_smp_en;
            w_ncmEn     = i_ncm_en;
            w_mskEn     = i_msk_en;
            w_done      = 1'b1;
          end else begin
            w_nextState = GATE_OFF;
            w_smpEn     = 1'b0;
            w_ncmEn     = 1'b0;
            w_mskEn     = 1'b0;
            w_cnt       = GW_LOAD;
          end
        end
      end
      GATE_OFF: begin
        w_cnt = r_cnt - CW'(1);
        if (w_cntZero) begin
          w_nextState = CLK_OFF;
          w_clkEn     = 1'b0;
          w_cnt       = GW_LOAD;
        end
      end
      CLK_OFF: begin
        w_cnt = r_cnt - CW'(1);
        if (w_cntZero) begin
          w_nextState = APPLY;
          w_divRstN   = 1'b0;
          w_clkDiv    = r_shDiv;
          w_oscEn     = r_shOsc;
          w_oscChg    = (r_shOsc != r_oscEn);
        end
      end
      APPLY: begin
        w_nextState = SETTLE;
        w_cnt       = r_oscChg ? OS_LOAD : GW_LOAD;
      end
      SETTLE: begin
        w_cnt = r_cnt - CW'(1);
        if (w_cntZero) begin
          w_nextState = CLK_ON;
          w_divRstN   = 1'b1;
          w_clkEn     = 1'b1;
          w_cnt       = GW_LOAD;
        end
      end
      CLK_ON: begin
        w_cnt = r_cnt - CW'(1);
        if (w_cntZero) begin
          w_nextState = GATE_ON;
          w_smpEn     = r_shSmp;
          w_ncmEn     = r_shNcm;
          w_mskEn     = r_shMsk;
          w_done      = 1'b1;
        end
      end
      GATE_ON: begin
        w_nextState = IDLE;
        w_busy      = 1'b0;
      end
      default: begin
        w_nextState = IDLE;
        w_busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shOsc   <= 1'b0;
      r_shDiv   <= 3'd0;
      r_shSmp   <= 1'b0;
      r_shNcm   <= 1'b0;
      r_shMsk   <= 1'b0;
      r_oscChg  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
      r_oscEn   <= 1'b0;
      r_clkEn   <= 1'b0;
      r_clkDiv  <= 3'd0;
      r_divRstN <= 1'b0;
      r_smpEn   <= 1'b0;
      r_ncmEn   <= 1'b0;
      r_mskEn   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_cnt;
      r_shOsc   <= w_shOsc;
      r_shDiv   <= w_shDiv;
      r_shSmp   <= w_shSmp;
      r_shNcm   <= w_shNcm;
      r_shMsk   <= w_shMsk;
      r_oscChg  <= w_oscChg;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_drop    <= w_drop;
      r_oscEn   <= w_oscEn;
      r_clkEn   <= w_clkEn;
      r_clkDiv  <= w_clkDiv;
      r_divRstN <= w_divRstN;
      r_smpEn   <= w_smpEn;
      r_ncmEn   <= w_ncmEn;
      r_mskEn   <= w_mskEn;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_drop      = r_drop;
  assign o_osc_en    = r_oscEn;
  assign o_clk_en    = r_clkEn;
  assign o_clk_div   = r_clkDiv;
  assign o_div_rst_n = r_divRstN;
  assign o_smp_en    = r_smpEn;
  assign o_ncm_en    = r_ncmEn;
  assign o_msk_en    = r_mskEn;

endmodule

// File: tb/tb_clkg_seq.sv
// Directed bench for clkg_seq: stimulus pushes expected completions, a monitor checks each o_done pulse.
module tb_clkg_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req, i_osc_en, i_smp_en, i_ncm_en, i_msk_en;
  logic [2:0] i_div;
  logic       o_busy, o_done, o_drop, o_osc_en, o_clk_en, o_div_rst_n;
  logic       o_smp_en, o_ncm_en, o_msk_en;
  logic [2:0] o_clk_div;

  clkg_seq #(.GATE_WAIT(4), .OSC_SETTLE(64)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_osc_en(i_osc_en), .i_div(i_div),
    .i_smp_en(i_smp_en), .i_ncm_en(i_ncm_en), .i_msk_en(i_msk_en),
    .o_busy(o_busy), .o_done(o_done), .o_drop(o_drop), .o_osc_en(o_osc_en),
    .o_clk_en(o_clk_en), .o_clk_div(o_clk_div), .o_div_rst_n(o_div_rst_n),
    .o_smp_en(o_smp_en), .o_ncm_en(o_ncm_en), .o_msk_en(o_msk_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         doneCyc;
    logic       osc;
    logic [2:0] div;
    logic       smp;
    logic       ncm;
    logic       msk;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Completion monitor: every o_done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("done_cycle", cyc, e.doneCyc);
        checkOutput("done_osc", o_osc_en, e.osc);
        checkOutput("done_div", o_clk_div, e.div);
        checkOutput("done_branches", {o_smp_en, o_ncm_en, o_msk_en}, {e.smp, e.ncm, e.msk});
        checkOutput("done_root", {o_clk_en, o_div_rst_n, o_busy}, 3'b111);
      end
    end
  end

  task automatic waitToCycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drives a one-cycle request; k returns the acceptance cycle (cycle 0).
  task automatic applyStimulus(input logic osc, input logic [2:0] div, input logic smp,
                               input logic ncm, input logic msk, input int lat, output int k);
    exp_t e;
    @(negedge clk);
    i_req = 1'b1; i_osc_en = osc; i_div = div;
    i_smp_en = smp; i_ncm_en = ncm; i_msk_en = msk;
    k = cyc;
    if (lat > 0) begin
      e.doneCyc = k + lat; e.osc = osc; e.div = div;
      e.smp = smp; e.ncm = ncm; e.msk = msk;
      expQ.push_back(e);
    end
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && o_busy; i++) @(negedge clk);
    checkOutput("idle_timeout", o_busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput(name, {o_busy, o_done, o_drop, o_osc_en, o_clk_en, o_clk_div,
                       o_div_rst_n, o_smp_en, o_ncm_en, o_msk_en}, 12'h000);
  endtask

  int k;
  int fastLat;

  initial begin
    rst = 1'b1; i_req = 1'b0; i_osc_en = 1'b0; i_div = 3'd0;
    i_smp_en = 1'b0; i_ncm_en = 1'b0; i_msk_en = 1'b0;
`ifdef CLKG_SEQ_FASTPATH_EN
    fastLat = 1;
`else
    fastLat = 18;
`endif
    repeat (3) @(negedge clk);
    checkResetOutputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("post_reset");

    // A: osc unchanged, SETTLE uses GATE_WAIT
    applyStimulus(1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 18, k);
    checkOutput("A_busy_c1", o_busy, 1'b1);
    waitToCycle(k + 9);
    checkOutput("A_div_c9", o_clk_div, 3'd3);
    waitToCycle(k + 13);
    checkOutput("A_root_c13", {o_clk_en, o_div_rst_n}, 2'b00);
    waitToCycle(k + 14);
    checkOutput("A_root_c14", {o_clk_en, o_div_rst_n}, 2'b11);
    waitToCycle(k + 17);
    checkOutput("A_smp_c17", o_smp_en, 1'b0);
    waitIdle();

    // B: osc changes, plus a dropped request at cycle 6
    applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 78, k);
    checkOutput("B_gates_c1", {o_smp_en, o_ncm_en, o_msk_en}, 3'b000);
    waitToCycle(k + 4);
    checkOutput("B_clk_c4", o_clk_en, 1'b1);
    waitToCycle(k + 5);
    checkOutput("B_clk_c5", o_clk_en, 1'b0);
    waitToCycle(k + 6);
    i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    checkOutput("B_drop_c7", o_drop, 1'b1);
    waitToCycle(k + 8);
    checkOutput("B_pre_apply_c8", {o_osc_en, o_div_rst_n, o_clk_div}, {1'b0, 1'b1, 3'd3});
    waitToCycle(k + 9);
    checkOutput("B_apply_c9", {o_osc_en, o_div_rst_n, o_clk_div}, {1'b1, 1'b0, 3'd0});
    waitToCycle(k + 73);
    checkOutput("B_clk_c73", o_clk_en, 1'b0);
    waitToCycle(k + 74);
    checkOutput("B_clk_c74", {o_clk_en, o_div_rst_n}, 2'b11);
    waitToCycle(k + 78);
    checkOutput("B_drop_c78", o_drop, 1'b1);
    waitIdle();

    // C: same osc/div, smp toggled 1->0
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, fastLat, k);
    checkOutput("C_drop_clr", o_drop, 1'b0);
    checkOutput("C_smp_c1", o_smp_en, 1'b0);
    checkOutput("C_clk_c1", o_clk_en, 1'b1);
`ifdef CLKG_SEQ_FASTPATH_EN
    checkOutput("C_msk_c1", o_msk_en, 1'b1);
    @(negedge clk);
    checkOutput("C_busy_c2", o_busy, 1'b0);
    checkOutput("C_clk_c2", o_clk_en, 1'b1);
`else
    checkOutput("C_msk_c1", o_msk_en, 1'b0);
`endif
    waitIdle();

    // D: inputs change after acceptance; captured values must win
    applyStimulus(1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 78, k);
    i_osc_en = 1'b1; i_div = 3'd7; i_smp_en = 1'b0; i_ncm_en = 1'b0; i_msk_en = 1'b1;
    waitToCycle(k + 9);
    checkOutput("D_apply_c9", {o_osc_en, o_clk_div}, {1'b0, 3'd5});
    waitIdle();

    // E: reset asserted during SETTLE
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 0, k);
    waitToCycle(k + 20);
    checkOutput("E_settle_c20", {o_busy, o_div_rst_n, o_osc_en}, 3'b101);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("E_reset_mid");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("E_reset_hold");

    // F: fresh request after reset completes normally
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 18, k);
    waitToCycle(k + 14);
    checkOutput("F_root_c14", {o_clk_en, o_div_rst_n}, 2'b11);
    waitIdle();

    checkOutput("pending_done", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
